i2c_pad_bank: RTL

I2C_PAD_BANK -- requirements
Module: i2c_pad_bank

---
 rtl/i2c_pad_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2c_pad_bank.sv
// Open-drain I2C pad bank: per-channel synchronisers, glitch filters, arbitration monitor and heartbeat LEDs.
// START/STOP/busy monitoring is compiled in only with I2C_PAD_BANK_BUSMON_EN defined.
module i2c_pad_bank #(
    parameter int CH      = 1,
    parameter int FILT    = 3,
    parameter int LED_W   = 4,
    parameter int LED_MSB = 22
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [CH-1:0]    SCL,
    inout  wire  [CH-1:0]    SDA,
    input  logic [CH-1:0]    scl_pad_o,
    input  logic [CH-1:0]    sda_pad_o,
    input  logic [CH-1:0]    scl_padoen_o,
    input  logic [CH-1:0]    sda_padoen_o,
    input  logic [CH-1:0]    sda_tx_en,
    output logic [CH-1:0]    scl_pad_i,
    output logic [CH-1:0]    sda_pad_i,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    start_det,
    output logic [CH-1:0]    stop_det,
    output logic [CH-1:0]    arb_lost,
    input  logic [CH-1:0]    arb_clr,
    output logic [LED_W-1:0] GPIO_LED
);

    logic [CH-1:0] scl_s1, scl_s2, sda_s1, sda_s2;
    logic [CH-1:0] scl_f, sda_f, scl_f_nxt, sda_f_nxt;
    logic [3:0]    scl_cnt [CH];
    logic [3:0]    sda_cnt [CH];
    logic [3:0]    scl_cnt_nxt [CH];
    logic [3:0]    sda_cnt_nxt [CH];
    logic [CH-1:0] arb_set;
    logic [31:0]   hb_cnt;

    // Pads are purely combinational so the core can drive them even while RESET is held.
    for (genvar g = 0; g < CH; g++) begin : g_pad
        assign SCL[g] = scl_padoen_o[g] ? 1'bz : scl_pad_o[g];
        assign SDA[g] = sda_padoen_o[g] ? 1'bz : sda_pad_o[g];
    end

    // Returns {next filtered value, next run counter}; any sample equal to the current value restarts the run.
    function automatic logic [4:0] filt_step(input logic smp, input logic cur, input logic [3:0] cnt);
        logic [4:0] r;
        r = {cur, 4'd0};
        if (smp != cur) begin
            if (cnt == 4'(FILT - 1)) begin
                r = {smp, 4'd0};
            end else begin
                r = {cur, cnt + 4'd1};
            end
        end
        return r;
    endfunction

    always_comb begin
        scl_f_nxt   = scl_f;
        sda_f_nxt   = sda_f;
        scl_cnt_nxt = scl_cnt;
        sda_cnt_nxt = sda_cnt;
        for (int unsigned i = 0; i < CH; i++) begin
            {scl_f_nxt[i], scl_cnt_nxt[i]} = filt_step(scl_s2[i], scl_f[i], scl_cnt[i]);
            {sda_f_nxt[i], sda_cnt_nxt[i]} = filt_step(sda_s2[i], sda_f[i], sda_cnt[i]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scl_s1 <= '1;
            scl_s2 <= '1;
            sda_s1 <= '1;
            sda_s2 <= '1;
            scl_f  <= '1;
            sda_f  <= '1;
            for (int unsigned i = 0; i < CH; i++) begin
                scl_cnt[i] <= '0;
                sda_cnt[i] <= '0;
            end
        end else begin
            scl_s1  <= SCL;
            scl_s2  <= scl_s1;
            sda_s1  <= SDA;
            sda_s2  <= sda_s1;
            scl_f   <= scl_f_nxt;
            sda_f   <= sda_f_nxt;
            scl_cnt <= scl_cnt_nxt;
            sda_cnt <= sda_cnt_nxt;
        end
    end

    assign scl_pad_i = scl_f;
    assign sda_pad_i = sda_f;

    // Evaluated on the edge where filtered SCL rises, against the SDA value seen in that same cycle.
    assign arb_set = ~scl_f & scl_f_nxt & sda_tx_en & sda_padoen_o & ~sda_f_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            arb_lost <= '0;
        end else begin
            arb_lost <= arb_set | (arb_lost & ~arb_clr);
        end
    end

`ifdef I2C_PAD_BANK_BUSMON_EN
    logic [CH-1:0] scl_hi, start_c, stop_c;

    // Conditions use current and next filtered values so the pulse and busy appear with the SDA edge on sda_pad_i.
    assign scl_hi  = scl_f & scl_f_nxt;
    assign start_c = scl_hi & sda_f & ~sda_f_nxt;
    assign stop_c  = scl_hi & ~sda_f & sda_f_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            start_det <= '0;
            stop_det  <= '0;
            busy      <= '0;
        end else begin
            start_det <= start_c;
            stop_det  <= stop_c;
            busy      <= start_c | (busy & ~stop_c);
        end
    end
`else
    assign start_det = '0;
    assign stop_det  = '0;
    assign busy      = '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end

    assign GPIO_LED = hb_cnt[LED_MSB -: LED_W];

endmodule
